// File: rtl/cf_fusion.sv
// cf_fusion: complementary-filter angle fusion of gyro increments and accelerometer angles,
// one channel per CALC cycle over a single shared datapath.
module cf_fusion #(
   parameter int NCH  = 3,
   parameter int GW   = 20,
   parameter int AW   = 16,
   parameter int FULL = 23040,
   parameter int K    = 5
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              init,
   input  logic [NCH*GW-1:0] gyro_inc,
   input  logic [NCH*AW-1:0] acc_angle,
   input  logic [NCH-1:0]    acc_ok,
   output logic              out_valid,
   output logic [NCH*AW-1:0] angle,
   output logic [NCH-1:0]    acc_oor
);
   localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
   localparam int XW = GW > AW + 2 ? GW : AW + 2;
   localparam int EW = AW + 2;
   localparam logic signed [XW-1:0] LIM  = XW'(FULL - 1);
   localparam logic signed [EW-1:0] FE   = EW'(FULL);
   localparam logic signed [EW-1:0] HALF = EW'(FULL / 2);
   typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;
   state_t              r_state;
   logic [CW-1:0]       r_ch;
   logic [NCH*GW-1:0]   r_gyro;
   logic [NCH*AW-1:0]   r_acc, r_st, r_angle;
   logic [NCH-1:0]      r_ok, r_oor;
   logic                r_init, r_ov;
   logic signed [GW-1:0] w_g;
   logic signed [XW-1:0] w_gx, w_inc;
   logic signed [EW-1:0] w_s, w_p, w_a, w_e0, w_e, w_n0, w_n;
   logic [AW-1:0]       w_acc, w_new;
   logic                w_ok, w_oor, w_last;
   logic [NCH*AW-1:0]   w_st_nx;
   always_comb begin
      w_g     = r_gyro[r_ch*GW +: GW];
      w_acc   = r_acc[r_ch*AW +: AW];
      w_gx    = XW'(w_g);
      w_inc   = w_gx > LIM ? LIM : (w_gx < -LIM ? -LIM : w_gx);
      w_s     = $signed({2'b00, r_st[r_ch*AW +: AW]}) + $signed(w_inc[EW-1:0]);
      w_p     = w_s < 0 ? w_s + FE : (w_s >= FE ? w_s - FE : w_s);
      w_a     = $signed({2'b00, w_acc});
      w_ok    = r_ok[r_ch] && (w_acc < AW'(FULL));
      w_oor   = r_ok[r_ch] && (w_acc >= AW'(FULL));
      // error taken along the shortest arc so blending never goes the long way round
      w_e0    = w_a - w_p;
      w_e     = w_e0 > HALF ? w_e0 - FE : (w_e0 <= -HALF ? w_e0 + FE : w_e0);
      w_n0    = w_p + (w_e >>> K);
      w_n     = w_n0 < 0 ? w_n0 + FE : (w_n0 >= FE ? w_n0 - FE : w_n0);
      w_new   = !w_ok ? w_p[AW-1:0] : (r_init ? w_acc : w_n[AW-1:0]);
      w_st_nx = r_st;
      w_st_nx[r_ch*AW +: AW] = w_new;
      w_last  = r_ch == CW'(NCH - 1);
   end
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         r_state <= IDLE;
         r_ch    <= '0;
         r_gyro  <= '0;
         r_acc   <= '0;
         r_ok    <= '0;
         r_init  <= 1'b0;
         r_st    <= '0;
         r_angle <= '0;
         r_oor   <= '0;
         r_ov    <= 1'b0;
      end else begin
         r_ov <= 1'b0;
         case (r_state)
            IDLE: if (in_valid) begin
               r_gyro  <= gyro_inc;
               r_acc   <= acc_angle;
               r_ok    <= acc_ok;
               r_init  <= init;
               r_ch    <= '0;
               r_state <= CALC;
               if (init) r_oor <= '0;
            end
            CALC: begin
               r_st <= w_st_nx;
               r_ch <= w_last ? '0 : r_ch + 1'b1;
               if (w_oor) r_oor[r_ch] <= 1'b1;
               if (w_last) begin
                  r_angle <= w_st_nx;
                  r_ov    <= 1'b1;
                  r_state <= OUT;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign in_ready  = r_state == IDLE;
   assign out_valid = r_ov;
   assign angle     = r_angle;
   assign acc_oor   = r_oor;
endmodule

// File: tb/tb_cf_fusion.sv
// tb_cf_fusion: table-driven checks of cf_fusion plus handshake and reset-abort sequences.
module tb_cf_fusion;
   localparam int NCH = 3;
   localparam int GW  = 20;
   localparam int AW  = 16;
   logic              clk = 1'b0;
   logic              RST = 1'b0;
   logic              in_valid = 1'b0;
   logic              init = 1'b0;
   logic [NCH*GW-1:0] gyro_inc = '0;
   logic [NCH*AW-1:0] acc_angle = '0;
   logic [NCH-1:0]    acc_ok = '0;
   logic              in_ready, out_valid;
   logic [NCH*AW-1:0] angle;
   logic [NCH-1:0]    acc_oor;
   int n_chk = 0;
   int n_err = 0;
   typedef struct {
      logic       ini;
      int         g0, g1, g2, a0, a1, a2;
      logic [2:0] ok;
      int         e0, e1, e2;
      logic [2:0] eo;
   } vec_t;
   always #5 clk = ~clk;
   cf_fusion #(.NCH(NCH), .GW(GW), .AW(AW), .FULL(23040), .K(5)) dut (
      .clk(clk), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .init(init),
      .gyro_inc(gyro_inc), .acc_angle(acc_angle), .acc_ok(acc_ok),
      .out_valid(out_valid), .angle(angle), .acc_oor(acc_oor)
   );
   function automatic int ch(input int c);
      return int'(angle[c*AW +: AW]);
   endfunction
   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic ini, input int g0, g1, g2, a0, a1, a2, input logic [2:0] ok);
      init      = ini;
      gyro_inc  = {GW'(g2), GW'(g1), GW'(g0)};
      acc_angle = {AW'(a2), AW'(a1), AW'(a0)};
      acc_ok    = ok;
   endtask
   task automatic check_out(input string nm, input int e0, e1, e2, input logic [2:0] eo);
      chk({nm, " ch0"}, ch(0), e0);
      chk({nm, " ch1"}, ch(1), e1);
      chk({nm, " ch2"}, ch(2), e2);
      chk({nm, " oor"}, int'(acc_oor), int'(eo));
   endtask
   task automatic sample(input string nm, input vec_t v);
      int w;
      int lat;
      w = 0;
      while (!in_ready && w < 20) begin
         step();
         w++;
      end
      chk({nm, " ready"}, int'(in_ready), 1);
      drive(v.ini, v.g0, v.g1, v.g2, v.a0, v.a1, v.a2, v.ok);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      drive(1'b0, 12345, -999, 777, 9999, 9999, 9999, 3'b111);
      lat = 0;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      chk({nm, " latency"}, lat, 3);
      check_out(nm, v.e0, v.e1, v.e2, v.eo);
      step();
      chk({nm, " pulse"}, int'(out_valid), 0);
      chk({nm, " hold"}, ch(0), v.e0);
   endtask
   initial begin
      vec_t tv[17];
      int   any_ov;
      tv[0]  = '{1'b0, 640, 0, 0, 0, 0, 0, 3'b000, 640, 0, 0, 3'b000};
      tv[1]  = '{1'b1, 999, 0, 0, 22976, 1000, 2000, 3'b111, 22976, 1000, 2000, 3'b000};
      tv[2]  = '{1'b0, 128, 0, 0, 0, 0, 0, 3'b000, 64, 1000, 2000, 3'b000};
      tv[3]  = '{1'b0, -128, 0, 0, 0, 0, 0, 3'b000, 22976, 1000, 2000, 3'b000};
      tv[4]  = '{1'b1, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 3'b000};
      tv[5]  = '{1'b0, 0, 0, 0, 3200, 0, 0, 3'b001, 100, 0, 0, 3'b000};
      tv[6]  = '{1'b1, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 3'b000};
      tv[7]  = '{1'b0, 0, 0, 0, 22720, 0, 0, 3'b001, 23030, 0, 0, 3'b000};
      tv[8]  = '{1'b1, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 3'b000};
      tv[9]  = '{1'b0, 30000, -30000, 5, 0, 0, 0, 3'b000, 23039, 1, 5, 3'b000};
      tv[10] = '{1'b0, 0, 50, 0, 0, 23040, 0, 3'b010, 23039, 51, 5, 3'b010};
      tv[11] = '{1'b0, 0, 0, 0, 0, 0, 0, 3'b000, 23039, 51, 5, 3'b010};
      tv[12] = '{1'b1, 0, 0, 0, 100, 100, 100, 3'b111, 100, 100, 100, 3'b000};
      tv[13] = '{1'b0, 0, 0, 0, 99, 23040, 200, 3'b101, 99, 100, 103, 3'b000};
      tv[14] = '{1'b1, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 3'b000};
      tv[15] = '{1'b0, 0, 0, 0, 11520, 0, 0, 3'b001, 360, 0, 0, 3'b000};
      tv[16] = '{1'b1, 10, 0, 0, 5000, 0, 0, 3'b000, 370, 0, 0, 3'b000};
      #1;
      chk("rst ready", int'(in_ready), 1);
      chk("rst valid", int'(out_valid), 0);
      check_out("rst", 0, 0, 0, 3'b000);
      step();
      RST = 1'b1;
      for (int i = 0; i < 17; i++) sample($sformatf("vec%0d", i), tv[i]);
      sample("hs init", '{1'b1, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 3'b000});
      in_valid = 1'b1;
      for (int i = 0; i < 15; i++) begin
         drive(1'b0, 100 + i, 0, 0, 0, 0, 0, 3'b000);
         chk($sformatf("hs ready%0d", i), int'(in_ready), int'(i % 5 == 0));
         step();
         chk($sformatf("hs valid%0d", i), int'(out_valid), int'(i % 5 == 3));
      end
      in_valid = 1'b0;
      check_out("hs sum", 315, 0, 0, 3'b000);
      sample("oor set", '{1'b0, 0, 0, 0, 0, 23040, 0, 3'b010, 315, 0, 0, 3'b010});
      drive(1'b0, 5, 5, 5, 0, 23040, 0, 3'b010);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      #2;
      RST = 1'b0;
      #1;
      chk("abort ready", int'(in_ready), 1);
      chk("abort valid", int'(out_valid), 0);
      check_out("abort", 0, 0, 0, 3'b000);
      any_ov = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         any_ov |= int'(out_valid);
      end
      chk("abort no pulse", any_ov, 0);
      RST = 1'b1;
      sample("post rst", '{1'b0, 7, 0, 0, 0, 0, 0, 3'b000, 7, 0, 0, 3'b000});
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
